spi_slave_display_top: RTL and testbench

// - FPGA top level: SPI slave (mode 0, MSB first) receives bytes from an external master.
// - Shows the last two received bytes as 4 hex digits on a multiplexed common-cathode 7-segment display.
// - Echoes the previously received byte back on MISO.
// - All logic runs in the Clock domain; SCK/CS/MOSI are async inputs, oversampled.

---
 rtl/spi_slave_display_pkg.sv | 16 +
 rtl/slave_spi.sv | 91 +++++++++
 rtl/spi_slave_display_top.sv | 83 ++++++++
 tb/tb_spi_slave_display_top.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_display_pkg.sv
// Constants shared by the SPI slave and the multiplexed 7-segment display.
// The table is {dp,g,f,e,d,c,b,a}, active high.
package spi_slave_display_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIG_W  = $clog2(DIGITS);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = $clog2(BYTE_W);

  // Entry 0 is the rightmost (least significant) element of the packed array.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/slave_spi.sv
// SPI mode-0 slave, MSB first, oversampled in the system clock domain.
// Echoes the last completed byte on MISO during the following byte.
module slave_spi
  import spi_slave_display_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              Done_o,
  output logic [BYTE_W-1:0] DataReceived_o
);

  logic [1:0]        cs_sync_q, sck_sync_q, mosi_sync_q;
  logic              cs_prev_q, sck_prev_q;
  logic [BYTE_W-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] data_q, data_d, tx_q, tx_d;
  logic              done_q, done_d, miso_q, miso_d;
  logic              cs_active, cs_fall, sck_rise, sck_fall, mosi_s;

  assign cs_active = ~cs_sync_q[1];
  assign cs_fall   = cs_active & cs_prev_q;
  assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall  = ~sck_sync_q[1] & sck_prev_q;
  assign mosi_s    = mosi_sync_q[1];

  // Synchronizers reset to the idle bus state so release never fakes an edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], CS};
      sck_sync_q  <= {sck_sync_q[0], SCK};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      cs_prev_q   <= cs_sync_q[1];
      sck_prev_q  <= sck_sync_q[1];
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      miso_q      <= miso_d;
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    tx_d    = tx_q;

    if (!cs_active) begin
      cnt_d = '0;
    end else if (sck_rise) begin
      shift_d = {shift_q[BYTE_W-3:0], mosi_s};
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(BYTE_W - 1)) begin
        data_d = {shift_q, mosi_s};
        done_d = 1'b1;
      end
    end

    // The falling edge that closes a byte (counter back at 0) must not shift the fresh echo byte.
    if (cs_fall || done_q) begin
      tx_d = data_q;
    end else if (cs_active && sck_fall && (cnt_q != '0)) begin
      tx_d = {tx_q[BYTE_W-2:0], 1'b0};
    end

    miso_d = cs_active & tx_d[BYTE_W-1];
  end

  assign MISO           = miso_q;
  assign Done_o         = done_q;
  assign DataReceived_o = data_q;

endmodule

// File: rtl/spi_slave_display_top.sv
// FPGA top: SPI slave feeding a 4-digit multiplexed common-cathode hex display
// that shows the last two received bytes.
module spi_slave_display_top
  import spi_slave_display_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = 25_000_000,
  parameter int unsigned REFRESH_HZ = 1_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CS,
  input  logic       SCK,
  input  logic       MOSI,
  output logic       MISO,
  output logic [3:0] Cathodes_o,
  output logic [7:0] Segments_o
);

  localparam int unsigned DIV   = CLOCK_HZ / REFRESH_HZ;
  localparam int unsigned REF_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic              rx_done;
  logic [BYTE_W-1:0] rx_data;

  slave_spi SlaveSPI_inst (
    .Clock          (Clock),
    .Reset          (Reset),
    .CS             (CS),
    .SCK            (SCK),
    .MOSI           (MOSI),
    .MISO           (MISO),
    .Done_o         (rx_done),
    .DataReceived_o (rx_data)
  );

  logic [15:0]      disp_q, disp_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [3:0]       cath_q, cath_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       nibble;
  logic             ref_wrap;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      disp_q    <= '0;
      ref_cnt_q <= '0;
      dig_q     <= '0;
      cath_q    <= 4'b1110;
      seg_q     <= SEG_TABLE[0];
    end else begin
      disp_q    <= disp_d;
      ref_cnt_q <= ref_cnt_d;
      dig_q     <= dig_d;
      cath_q    <= cath_d;
      seg_q     <= seg_d;
    end
  end

  // Cathodes and segments are both derived from the current digit so they switch on the same edge.
  always_comb begin
    disp_d    = disp_q;
    ref_cnt_d = ref_cnt_q + REF_W'(1);
    dig_d     = dig_q;
    ref_wrap  = (ref_cnt_q == REF_W'(DIV - 1));

    if (rx_done) begin
      disp_d = {disp_q[7:0], rx_data};
    end
    if (ref_wrap) begin
      ref_cnt_d = '0;
      dig_d     = dig_q + DIG_W'(1);
    end

    nibble = 4'(disp_q >> {dig_q, 2'b00});
    cath_d = ~(4'b0001 << dig_q);
    seg_d  = SEG_TABLE[nibble];
  end

  assign Cathodes_o = cath_q;
  assign Segments_o = seg_q;

endmodule

// File: tb/tb_spi_slave_display_top.sv
// Directed bench for spi_slave_display_top: SPI framing, echo, display mux and decode.
// A second instance with an 8-cycle digit period makes every digit quick to observe.
module tb_spi_slave_display_top;

  localparam int HALF_SLOW = 7894;
  localparam int HALF_FAST = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso, miso_f;
  logic [3:0] cath, cath_f;
  logic [7:0] seg, seg_f;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #20 clk = ~clk;

  spi_slave_display_top u_dut (
    .Clock(clk), .Reset(rst), .CS(cs), .SCK(sck), .MOSI(mosi),
    .MISO(miso), .Cathodes_o(cath), .Segments_o(seg)
  );

  spi_slave_display_top #(.CLOCK_HZ(800), .REFRESH_HZ(100)) u_fast (
    .Clock(clk), .Reset(rst), .CS(cs), .SCK(sck), .MOSI(mosi),
    .MISO(miso_f), .Cathodes_o(cath_f), .Segments_o(seg_f)
  );

  logic        done_h;
  logic [7:0]  data_h;
  logic [15:0] disp_h;
  assign done_h = u_dut.SlaveSPI_inst.Done_o;
  assign data_h = u_dut.SlaveSPI_inst.DataReceived_o;
  assign disp_h = u_dut.disp_q;

  // Receive monitor: logs each Done_o pulse, its byte and clocks since the last SCK rise.
  logic       sck_d = 1'b0;
  logic       done_prev = 1'b0;
  int         since = 0;
  int         wide_cnt = 0;
  logic [7:0] rx_q [$];
  int         lat_q [$];

  always @(posedge clk) begin
    sck_d <= sck;
    since <= (sck && !sck_d) ? 1 : since + 1;
  end

  always @(negedge clk) begin
    done_prev <= done_h;
    if (done_h && !done_prev) begin
      rx_q.push_back(data_h);
      lat_q.push_back(since);
    end
    if (done_h && done_prev) wide_cnt <= wide_cnt + 1;
  end

  task automatic send_bits(input logic [7:0] b, input int n, input int half, output logic [7:0] mb);
    mb = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #(half);
      sck = 1'b1;
      mb[7-i] = miso;
      #(half);
      sck = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cath !== 4'b1110 || seg !== 8'h3F) begin
      errors++;
      $display("FAIL reset_display: cath=%b seg=%h expected cath=1110 seg=3f", cath, seg);
    end
    checks++;
    if (miso !== 1'b0 || done_h !== 1'b0 || data_h !== 8'h00 || disp_h !== 16'h0000) begin
      errors++;
      $display("FAIL reset_spi: miso=%b done=%b data=%h disp=%h expected 0 0 00 0000", miso, done_h, data_h, disp_h);
    end
    rst = 1'b0;
  endtask

  task automatic test_refresh;
    logic [3:0] prev;
    int n;
    prev = cath;
    n = 0;
    while (cath === prev && n < 30000) begin @(negedge clk); n++; end
    checks++;
    if (cath !== 4'b1101) begin
      errors++;
      $display("FAIL refresh_digit1: cath=%b expected 1101", cath);
    end
    prev = cath;
    n = 0;
    while (cath === prev && n < 30000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 25000 || cath !== 4'b1011) begin
      errors++;
      $display("FAIL refresh_period: interval=%0d cath=%b expected 25000 1011", n, cath);
    end
  endtask

  task automatic test_stream;
    logic [7:0] tx [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
    logic [7:0] em [4] = '{8'h00, 8'h01, 8'h03, 8'h07};
    logic [7:0] mb;
    logic [15:0] exp_disp;
    int base, wbase, n;
    base = rx_q.size();
    wbase = wide_cnt;
    @(negedge clk);
    cs = 1'b0;
    #(HALF_SLOW);
    for (int i = 0; i < 4; i++) begin
      send_bits(tx[i], 8, HALF_SLOW, mb);
      checks++;
      if (mb !== em[i]) begin
        errors++;
        $display("FAIL stream_miso[%0d]: got %h expected %h", i, mb, em[i]);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rx_q.size() - base !== 4) begin
      errors++;
      $display("FAIL stream_count: got %0d pulses expected 4", rx_q.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (base + i >= rx_q.size() || rx_q[base+i] !== tx[i]) begin
        errors++;
        $display("FAIL stream_byte[%0d]: missing or wrong, expected %h", i, tx[i]);
      end else if (lat_q[base+i] < 3 || lat_q[base+i] > 4) begin
        errors++;
        $display("FAIL stream_latency[%0d]: got %0d clocks expected 3..4", i, lat_q[base+i]);
      end
    end
    checks++;
    if (wide_cnt - wbase !== 0) begin
      errors++;
      $display("FAIL done_width: %0d extra high cycles expected 0", wide_cnt - wbase);
    end
    checks++;
    if (disp_h !== 16'h070F) begin
      errors++;
      $display("FAIL stream_disp: got %h expected 070f", disp_h);
    end
    exp_disp = 16'h070F;
    for (int d = 0; d < 4; d++) begin
      n = 0;
      while (cath_f !== ~(4'b0001 << d) && n < 64) begin @(negedge clk); n++; end
      checks++;
      if (cath_f !== ~(4'b0001 << d) || seg_f !== seg_tab[exp_disp[d*4 +: 4]]) begin
        errors++;
        $display("FAIL stream_digit[%0d]: cath=%b seg=%h expected seg %h", d, cath_f, seg_f, seg_tab[exp_disp[d*4 +: 4]]);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] mb;
    int base;
    base = rx_q.size();
    send_bits(8'hA5, 4, HALF_SLOW, mb);
    @(negedge clk);
    cs = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_q.size() - base !== 0) begin
      errors++;
      $display("FAIL abort_partial: got %0d pulses expected 0", rx_q.size() - base);
    end
    cs = 1'b0;
    #(HALF_SLOW);
    send_bits(8'h3C, 8, HALF_SLOW, mb);
    repeat (20) @(negedge clk);
    checks++;
    if (rx_q.size() - base !== 1 || rx_q[rx_q.size()-1] !== 8'h3C) begin
      errors++;
      $display("FAIL abort_byte: pulses=%0d last=%h expected 1 3c", rx_q.size() - base, data_h);
    end
    checks++;
    if (mb !== 8'h0F || disp_h !== 16'h0F3C) begin
      errors++;
      $display("FAIL abort_echo: miso=%h disp=%h expected 0f 0f3c", mb, disp_h);
    end
  endtask

  task automatic test_reset_midbyte;
    logic [7:0] mb;
    int base;
    send_bits(8'hFF, 4, HALF_FAST, mb);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_h !== 1'b0 || data_h !== 8'h00 || disp_h !== 16'h0000 || miso !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: done=%b data=%h disp=%h miso=%b expected 0 00 0000 0", done_h, data_h, disp_h, miso);
    end
    checks++;
    if (cath !== 4'b1110 || seg !== 8'h3F) begin
      errors++;
      $display("FAIL midreset_display: cath=%b seg=%h expected 1110 3f", cath, seg);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cs = 1'b1;
    repeat (10) @(negedge clk);
    cs = 1'b0;
    repeat (10) @(negedge clk);
    base = rx_q.size();
    send_bits(8'h81, 8, HALF_FAST, mb);
    repeat (20) @(negedge clk);
    checks++;
    if (rx_q.size() - base !== 1 || data_h !== 8'h81 || disp_h !== 16'h0081) begin
      errors++;
      $display("FAIL midreset_byte: pulses=%0d data=%h disp=%h expected 1 81 0081", rx_q.size() - base, data_h, disp_h);
    end
    checks++;
    if (mb !== 8'h00) begin
      errors++;
      $display("FAIL midreset_echo: miso=%h expected 00", mb);
    end
  endtask

  task automatic test_decode;
    logic [7:0] bytes [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] mb;
    logic [15:0] exp_disp;
    int n;
    for (int p = 0; p < 4; p++) begin
      send_bits(bytes[2*p], 8, HALF_FAST, mb);
      send_bits(bytes[2*p+1], 8, HALF_FAST, mb);
      repeat (20) @(negedge clk);
      exp_disp = {bytes[2*p], bytes[2*p+1]};
      for (int d = 0; d < 4; d++) begin
        n = 0;
        while (cath_f !== ~(4'b0001 << d) && n < 64) begin @(negedge clk); n++; end
        checks++;
        if (cath_f !== ~(4'b0001 << d) || seg_f !== seg_tab[exp_disp[d*4 +: 4]]) begin
          errors++;
          $display("FAIL decode_%h: digit %0d cath=%b seg=%h expected %h", exp_disp[d*4 +: 4], d, cath_f, seg_f, seg_tab[exp_disp[d*4 +: 4]]);
        end
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    fork
      test_refresh();
      begin
        test_stream();
        test_abort();
      end
    join
    test_reset_midbyte();
    test_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
